// File: rtl/program_feeder.sv
// Program-memory server: loads a byte image over a valid/ready port into internal RAM
// and serves it to the control unit by program counter, holding the unit in reset when idle.
module program_feeder #(
    parameter int unsigned ADDR_W = 8,
    parameter bit          WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              halt,
    input  logic              pc_inc,
    output logic [7:0]        rom_data,
    output logic              cu_rst,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              cu_rst_q, cu_rst_d;
    logic              load_ready_q, load_ready_d;
    logic              mem_we;
    logic              pc_last;
    logic [7:0]        mem [DEPTH];

    assign pc_last = ({1'b0, pc_q} + (ADDR_W + 1)'(1)) == prog_len_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d  = StLoad;
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
                    done_d   = 1'b0;
                end else if (run_start && prog_len_q != '0) begin
                    state_d = StRun;
                    pc_d    = '0;
                end
            end
            StLoad: begin
                // A restart takes priority over a byte offered in the same cycle.
                if (load_start) begin
                    wr_ptr_d = '0;
                end else if (load_valid && load_ready_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (load_last) begin
                        prog_len_d = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                        state_d    = StIdle;
                    end else if (wr_ptr_q == '1) begin
                        prog_len_d = {1'b1, {ADDR_W{1'b0}}};
                        ovf_d      = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StRun: begin
                if (halt) begin
                    state_d = StIdle;
                end else if (pc_inc) begin
                    if (!pc_last) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end else if (WRAP) begin
                        pc_d = '0;
                    end else begin
                        // A full image makes this wrap to 0 by the modulo rule.
                        pc_d    = prog_len_q[ADDR_W-1:0];
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (load_start) begin
                    state_d  = StLoad;
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
                    done_d   = 1'b0;
                end else if (run_start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        cu_rst_d     = (state_d != StRun);
        load_ready_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cu_rst_q     <= 1'b1;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            cu_rst_q     <= cu_rst_d;
            load_ready_q <= load_ready_d;
        end
    end

    // RAM contents survive reset; prog_len=0 is what invalidates the image.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= load_data;
        end
    end

    assign rom_data   = (state_q == StRun && {1'b0, pc_q} < prog_len_q) ? mem[pc_q] : 8'h00;
    assign cu_rst     = cu_rst_q;
    assign load_ready = load_ready_q;
    assign pc         = pc_q;
    assign prog_len   = prog_len_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule
